adder_meas_sequencer: RTL
=========================

// Module: adder_meas_sequencer
// PURPOSE
//  Measurement sequencer upstream/downstream of wrapped_instrumented_adder_kogge.
//  - Drives operands a/b and the ring-enable into the instrumented adder.
//  - Times fixed measurement windows and captures the adder's ring-oscillation count.
//  - Accumulates N samples and returns sum (and optionally min/max) to LA via valid/ready.
// PARAMETERS
//  COUNT_W        32  width of adder ring count input
//  WIN_W          16  width of window-length register (clock cycles)
//  SAMP_W          8  width of sample-count register (1..2^SAMP_W-1)
//  SETTLE_CYCLES   2  idle cycles after ring disable before count is sampled (>=1)
// PORTS
//  wb_clk_i      in   1        system clock
//  wb_rst_n      in   1        asynchronous active-low reset
//  start         in   1        1-cycle pulse; begins a sequence when IDLE
//  abort         in   1        level; forces return to IDLE next cycle
//  cfg_a         in   32       operand A, latched on accepted start
//  cfg_b         in   32       operand B, latched on accepted start
//  cfg_window    in   WIN_W    ring-enable cycles per sample (0 treated as 1)
//  cfg_samples   in   SAMP_W   samples per sequence (0 treated as 1)
//  ring_count    in   COUNT_W  adder ring counter value (stable when ring disabled)
//  adder_a       out  32       operand to adder
//  adder_b       out  32       operand to adder
//  ring_en       out  1        enables adder ring oscillator / counter
//  ring_clr      out  1        1-cycle clear of adder counter
//  busy          out  1        high in any state except IDLE
//  res_valid     out  1        result available
//  res_ready     in   1        consumer accepts result
//  res_sum       out  COUNT_W+SAMP_W  accumulated count
//  res_min/max   out  COUNT_W  extreme sample counts (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; accumulator, sample counter cleared.
//  - Stimulus is configured through the wrapper; ports are driven as in every wrapped project.
//  - FSM (registered): IDLE->LOAD->RUN->SETTLE->CAPTURE->(LOAD | DONE)->IDLE.
//  - IDLE: start=1 latches cfg_*, clears acc/sample count -> LOAD. start ignored in other states.
//  - LOAD (1 cyc): adder_a/b hold latched operands; ring_clr=1.
//  - RUN: ring_en=1 for exactly cfg_window cycles (window counter counts down).
//  - SETTLE: ring_en=0 for SETTLE_CYCLES cycles.
//  - CAPTURE (1 cyc): acc += zero-extended ring_count; sample counter increments.
//    If count == cfg_samples -> DONE, else LOAD.
//  - Accumulator does not overflow for legal configs (width COUNT_W+SAMP_W).
//  - DONE: res_valid=1, res_* stable; when res_valid & res_ready, return to IDLE
//    on the next edge with res_valid=0. Result registers keep their value until the next start.
//  - Latency, start to res_valid:
//    1 + samples*(1 + window + SETTLE_CYCLES + 1) cycles after the start edge.
//  - abort has priority over all transitions:
//    next state IDLE, ring_en=0, res_valid=0, acc unchanged.
//  - start and abort in the same cycle: abort wins, remain IDLE.
//  - adder_a/b hold their value from the last start; they stay stable through IDLE.
//  - Async reset mid-run: immediate ring_en=0, all outputs 0.
// CONFIGURATION
//  - MEAS_MINMAX_EN defined:
//    res_min/res_max track the min/max ring_count captured in the sequence.
//    Both are initialised from the first sample.
//  - Undefined: res_min/res_max tied to 0 and no comparator logic.
// STRUCTURE
//  - Package adder_meas_pkg: state enum (IDLE, LOAD, RUN, SETTLE, CAPTURE, DONE),
//    default width localparams, sum-width function.
//  - Sub-module meas_window_timer: loadable down-counter with 'expired' flag,
//    reused for the RUN and SETTLE durations.
// TESTING
//  1. window=10, samples=1, ring_count=37 stable -> res_sum=37.
//     res_valid rises 15 cycles after start; ring_en high exactly 10 cycles.
//  2. samples=4, ring_count 5,9,2,7 per capture -> res_sum=23.
//     With MEAS_MINMAX_EN: min=2, max=9.
//  3. res_ready held low 20 cycles in DONE -> res_valid and res_sum stay stable;
//     raise res_ready -> IDLE next cycle, busy=0.
//  4. abort asserted during RUN -> next cycle IDLE, ring_en=0, res_valid=0;
//     a following start runs a clean sequence.
//  5. cfg_window=0, cfg_samples=0 -> treated as 1/1; a second start pulse during
//     RUN is ignored (exactly one sample accumulated).
//  6. wb_rst_n low mid-SETTLE -> all outputs 0 asynchronously;
//     after release, IDLE and start accepted.

Source files
------------

// File: rtl/adder_meas_pkg.sv
// Shared types and defaults for the adder measurement sequencer.
// Holds the FSM state enum, default widths and the result-width helper.
package adder_meas_pkg;

   localparam int unsigned DEF_COUNT_W       = 32;
   localparam int unsigned DEF_WIN_W         = 16;
   localparam int unsigned DEF_SAMP_W        = 8;
   localparam int unsigned DEF_SETTLE_CYCLES = 2;
   localparam int unsigned OPER_W            = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      SETTLE,
      CAPTURE,
      DONE
   } meas_state_t;

   // Sum of COUNT_W-wide samples over at most 2^SAMP_W-1 captures never overflows.
   function automatic int unsigned sum_width(input int unsigned count_w,
                                             input int unsigned samp_w);
      return count_w + samp_w;
   endfunction

endpackage

// File: rtl/meas_window_timer.sv
// Loadable down-counter timing the RUN and SETTLE durations.
// Loading N gives N+1 cycles until 'expired' (count reaches zero).
module meas_window_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/adder_meas_sequencer.sv
// Measurement sequencer for the instrumented Kogge-Stone adder ring oscillator.
// Define MEAS_MINMAX_EN to track per-sequence min/max ring counts.
module adder_meas_sequencer
   import adder_meas_pkg::*;
#(
   parameter int unsigned COUNT_W       = DEF_COUNT_W,
   parameter int unsigned WIN_W         = DEF_WIN_W,
   parameter int unsigned SAMP_W        = DEF_SAMP_W,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                                  wb_clk_i,
   input  logic                                  wb_rst_n,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [OPER_W-1:0]                     cfg_a,
   input  logic [OPER_W-1:0]                     cfg_b,
   input  logic [WIN_W-1:0]                      cfg_window,
   input  logic [SAMP_W-1:0]                     cfg_samples,
   input  logic [COUNT_W-1:0]                    ring_count,
   output logic [OPER_W-1:0]                     adder_a,
   output logic [OPER_W-1:0]                     adder_b,
   output logic                                  ring_en,
   output logic                                  ring_clr,
   output logic                                  busy,
   output logic                                  res_valid,
   input  logic                                  res_ready,
   output logic [sum_width(COUNT_W, SAMP_W)-1:0] res_sum,
   output logic [COUNT_W-1:0]                    res_min,
   output logic [COUNT_W-1:0]                    res_max
);

   localparam int unsigned     SUM_W       = sum_width(COUNT_W, SAMP_W);
   localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);

   meas_state_t       state, state_nxt;
   logic              start_pend;
   logic              accept;
   logic              launch;
   logic [OPER_W-1:0] a_q, b_q;
   logic [WIN_W-1:0]  win_q;
   logic [SAMP_W-1:0] samp_q, samp_cnt, samp_inc;
   logic [SUM_W-1:0]  acc;
   logic              tmr_load, tmr_en, tmr_exp;
   logic [WIN_W-1:0]  tmr_val;

   // A start seen in IDLE is registered first; the sequence launches on the following edge.
   assign accept   = start && !abort && (state == IDLE) && !start_pend;
   assign launch   = (state == IDLE) && start_pend && !abort;
   assign samp_inc = samp_cnt + 1'b1;
   assign tmr_en   = (state == RUN) || (state == SETTLE);

   meas_window_timer #(.W(WIN_W)) u_timer (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .expired  (tmr_exp)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= IDLE;
         start_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         start_pend <= accept;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_pend) state_nxt = LOAD;
            LOAD: begin
               state_nxt = RUN;
               tmr_load  = 1'b1;
               tmr_val   = win_q - 1'b1;
            end
            RUN: if (tmr_exp) begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
               tmr_val   = SETTLE_LOAD;
            end
            SETTLE:  if (tmr_exp) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (samp_inc == samp_q) ? DONE : LOAD;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         win_q    <= '0;
         samp_q   <= '0;
         samp_cnt <= '0;
         acc      <= '0;
      end else begin
         if (accept) begin
            a_q    <= cfg_a;
            b_q    <= cfg_b;
            win_q  <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;
            samp_q <= (cfg_samples == '0) ? SAMP_W'(1) : cfg_samples;
         end
         if (launch) begin
            acc      <= '0;
            samp_cnt <= '0;
         end else if ((state == CAPTURE) && !abort) begin
            acc      <= acc + SUM_W'(ring_count);
            samp_cnt <= samp_inc;
         end
      end
   end

`ifdef MEAS_MINMAX_EN
   logic [COUNT_W-1:0] min_q, max_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         min_q <= '0;
         max_q <= '0;
      end else if ((state == CAPTURE) && !abort) begin
         if ((samp_cnt == '0) || (ring_count < min_q)) min_q <= ring_count;
         if ((samp_cnt == '0) || (ring_count > max_q)) max_q <= ring_count;
      end
   end

   assign res_min = min_q;
   assign res_max = max_q;
`else
   assign res_min = '0;
   assign res_max = '0;
`endif

   assign adder_a   = a_q;
   assign adder_b   = b_q;
   assign ring_en   = (state == RUN);
   assign ring_clr  = (state == LOAD);
   assign busy      = (state != IDLE);
   assign res_valid = (state == DONE);
   assign res_sum   = acc;

endmodule
